calc_key_sequencer: RTL and testbench
=====================================

// Module: calc_key_sequencer
// PURPOSE
//   Turns the 5-bit numpad event stream into calculator transactions: collects decimal operand A,
//   an operator and operand B, issues one request to the arithmetic unit over a valid/ready
//   handshake, waits for its result and drives the display value. Sits between numpad and ALU.
// PARAMETERS
//   WIDTH   16  operand/result width in bits
//   DIGITS  4   max decimal digits per operand; further digit keys are dropped
// PORTS
//   clock       in   1      system clock (50 MHz), all logic on posedge
//   reset_n     in   1      synchronous reset, active-low
//   key_code    in   5      numpad event: 0 = none, 16+k = key index k pressed (one-cycle pulse)
//   alu_valid   out  1      request valid
//   alu_ready   in   1      ALU accepts request when alu_valid & alu_ready
//   alu_a       out  WIDTH  operand A, stable while alu_valid
//   alu_b       out  WIDTH  operand B, stable while alu_valid
//   alu_op      out  2      0 add, 1 sub, 2 mul, 3 div; stable while alu_valid
//   res_valid   in   1      one-cycle pulse, result available
//   res_value   in   WIDTH  result, sampled when res_valid
//   res_error   in   1      result error (e.g. divide by zero), sampled when res_valid
//   disp_value  out  WIDTH  value to display (operand being entered or last result)
//   disp_error  out  1      error indicator
//   busy        out  1      high in ISSUE and WAIT
// BEHAVIOUR
//   Key decode (index k): 0..15 -> 1,4,7,0,2,5,8,F,3,6,9,E,A,B,C,D. Codes 1..15 treated as none.
//   Digits 0-9; A add, B sub, C mul, D div; E equals; F clear.
//   Reset: state ENTER_A; A=B=0, op=0, digit counts 0; all outputs 0.
//   ENTER_A: digit -> A = A*10+d (mod 2^WIDTH) if countA<DIGITS, countA++; disp=A.
//     operator -> latch op, B=0, countB=0, go ENTER_B (A may be 0 with no digits). E ignored.
//   ENTER_B: digit -> B accumulates as A; disp=B (disp=A until first B digit).
//     operator -> replaces op if countB==0, else ignored. E -> ISSUE only if countB>0.
//   ISSUE: alu_valid=1, alu_a/b/op held constant; on alu_valid&alu_ready go WAIT next cycle,
//     alu_valid low in WAIT. Request latency: alu_valid rises cycle after E event.
//   WAIT: on res_valid: error -> ERROR, disp_error=1; else A=res_value, disp=res_value, SHOW.
//     res_valid outside WAIT ignored.
//   SHOW: digit -> A=d, countA=1, ENTER_A; operator -> chain with A=result, go ENTER_B; E ignored.
//   ERROR: every key except F ignored; disp_value=0.
//   F in ENTER_A/ENTER_B/SHOW/ERROR: A=B=0, counts 0, disp 0, disp_error 0, ENTER_A, next cycle.
//   All keys including F dropped while busy (ISSUE, WAIT); request never withdrawn.
//   Key event and state transition in same cycle: key evaluated against current state only.
//   reset_n low at any point (incl. ISSUE/WAIT) returns to reset values next edge; a result
//   arriving afterwards is ignored.
//   Leading zeros count as digits (0,0,1,2 fills DIGITS=4).
// TESTING
//   keys 1,2,A,3,E; ready=1 -> one alu_valid cycle with a=12 b=3 op=0; res 15 -> disp 15.
//   keys 1,2,3,4,5 -> disp 1234 (fifth digit dropped); then F -> disp 0, ENTER_A.
//   alu_ready low 3 cycles in ISSUE, keys 7 and F pressed -> alu_valid held, a/b/op constant,
//   keys dropped, handshake completes on 4th cycle.
//   keys 8,D,0,E; res_error=1 -> disp_error=1, disp 0; key 5 ignored; F clears error.
//   result 15 shown; keys B,5,E -> alu_a=15 b=5 op=1; res 10 -> disp 10; key 4 -> disp 4.
//   reset_n low during WAIT -> outputs 0; later res_valid ignored; key 9 -> disp 9.

Source files
------------

// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer
//   Turns numpad key events into calculator transactions. Collects a decimal
//   operand A, an operator and an operand B, issues one request to the
//   arithmetic unit, waits for the result and drives the display value.
//
// Ports
//   clock       in   system clock, all logic on posedge
//   reset_n     in   synchronous reset, active-low
//   key_code    in   5-bit key event: 0 none, 16+k key index k (one-cycle pulse)
//   alu_valid   out  request valid
//   alu_ready   in   request accepted when alu_valid & alu_ready
//   alu_a       out  operand A, stable while alu_valid
//   alu_b       out  operand B, stable while alu_valid
//   alu_op      out  0 add, 1 sub, 2 mul, 3 div; stable while alu_valid
//   res_valid   in   one-cycle pulse, result available
//   res_value   in   result value, sampled when res_valid
//   res_error   in   result error flag, sampled when res_valid
//   disp_value  out  value to display
//   disp_error  out  error indicator
//   busy        out  high while a request is outstanding (ISSUE, WAIT_RES)
//   fsm_state   out  debug view of the sequencer state
//
// ALU handshake: a request is presented by raising alu_valid with alu_a,
// alu_b and alu_op held constant; it is transferred on the first rising edge
// where alu_valid and alu_ready are both high, and is never withdrawn before
// that edge.
module calc_key_sequencer #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [4:0]       key_code,
    output logic             alu_valid,
    input  logic             alu_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] res_value,
    input  logic             res_error,
    output logic [WIDTH-1:0] disp_value,
    output logic             disp_error,
    output logic             busy,
    output logic [2:0]       fsm_state
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(DIGITS);

    typedef enum logic [2:0] {
        ENTER_A  = 3'd0,
        ENTER_B  = 3'd1,
        ISSUE    = 3'd2,
        WAIT_RES = 3'd3,
        SHOW     = 3'd4,
        ERROR    = 3'd5
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic [CW-1:0]    cnt_a;
    logic [CW-1:0]    cnt_b;

    // Key decode: key_val 0..9 are digits, 10..13 operators A..D,
    // 14 equals (E), 15 clear (F). Codes 1..15 have bit 4 low and decode as no key.
    logic       key_hit;
    logic [3:0] key_val;
    logic       is_digit;
    logic       is_oper;
    logic       is_equal;
    logic       is_clear;
    logic [1:0] oper_code;

    always_comb begin
        key_hit = key_code[4];
        case (key_code[3:0])
            4'd0:    key_val = 4'd1;
            4'd1:    key_val = 4'd4;
            4'd2:    key_val = 4'd7;
            4'd3:    key_val = 4'd0;
            4'd4:    key_val = 4'd2;
            4'd5:    key_val = 4'd5;
            4'd6:    key_val = 4'd8;
            4'd7:    key_val = 4'd15;
            4'd8:    key_val = 4'd3;
            4'd9:    key_val = 4'd6;
            4'd10:   key_val = 4'd9;
            4'd11:   key_val = 4'd14;
            4'd12:   key_val = 4'd10;
            4'd13:   key_val = 4'd11;
            4'd14:   key_val = 4'd12;
            default: key_val = 4'd13;
        endcase
        is_digit  = key_hit && (key_val <= 4'd9);
        is_oper   = key_hit && (key_val >= 4'd10) && (key_val <= 4'd13);
        is_equal  = key_hit && (key_val == 4'd14);
        is_clear  = key_hit && (key_val == 4'd15);
        oper_code = 2'(key_val - 4'd10);
    end

    // acc*10 + d, wrapping modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] acc,
                                                  input logic [3:0] d);
        return (acc << 3) + (acc << 1) + WIDTH'(d);
    endfunction

    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;

    always_comb begin
        a_next = shift_in(a, key_val);
        b_next = shift_in(b, key_val);
    end

    assign busy      = (state == ISSUE) || (state == WAIT_RES);
    assign fsm_state = state;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= ENTER_A;
            a          <= '0;
            b          <= '0;
            op         <= 2'd0;
            cnt_a      <= '0;
            cnt_b      <= '0;
            alu_valid  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= 2'd0;
            disp_value <= '0;
            disp_error <= 1'b0;
        end else if (is_clear && !busy) begin
            // Clear works from every idle state, including ERROR.
            state      <= ENTER_A;
            a          <= '0;
            b          <= '0;
            op         <= 2'd0;
            cnt_a      <= '0;
            cnt_b      <= '0;
            disp_value <= '0;
            disp_error <= 1'b0;
        end else begin
            case (state)
                ENTER_A: begin
                    if (is_digit) begin
                        if (cnt_a < MAX_CNT) begin
                            a          <= a_next;
                            cnt_a      <= cnt_a + CW'(1);
                            disp_value <= a_next;
                        end
                    end else if (is_oper) begin
                        op    <= oper_code;
                        b     <= '0;
                        cnt_b <= '0;
                        state <= ENTER_B;
                    end
                end
                ENTER_B: begin
                    // The display keeps showing A until the first B digit lands.
                    if (is_digit) begin
                        if (cnt_b < MAX_CNT) begin
                            b          <= b_next;
                            cnt_b      <= cnt_b + CW'(1);
                            disp_value <= b_next;
                        end
                    end else if (is_oper) begin
                        if (cnt_b == '0) begin
                            op <= oper_code;
                        end
                    end else if (is_equal) begin
                        if (cnt_b != '0) begin
                            alu_a     <= a;
                            alu_b     <= b;
                            alu_op    <= op;
                            alu_valid <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (alu_ready) begin
                        alu_valid <= 1'b0;
                        state     <= WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    if (res_valid) begin
                        if (res_error) begin
                            disp_error <= 1'b1;
                            disp_value <= '0;
                            state      <= ERROR;
                        end else begin
                            a          <= res_value;
                            disp_value <= res_value;
                            state      <= SHOW;
                        end
                    end
                end
                SHOW: begin
                    // A already holds the result, so an operator chains from it.
                    if (is_digit) begin
                        a          <= WIDTH'(key_val);
                        cnt_a      <= CW'(1);
                        disp_value <= WIDTH'(key_val);
                        state      <= ENTER_A;
                    end else if (is_oper) begin
                        op    <= oper_code;
                        b     <= '0;
                        cnt_b <= '0;
                        state <= ENTER_B;
                    end
                end
                ERROR: begin
                    disp_value <= '0;
                end
                default: begin
                    state <= ENTER_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Testbench for calc_key_sequencer: directed scenarios plus a randomized key
// stream, all checked against a key-level calculator model.
module tb_calc_key_sequencer;

    localparam int W = 16;
    localparam int M_A = 0, M_B = 1, M_BUSY = 2, M_SHOW = 3, M_ERR = 4;

    // ---------------- clock / reset / DUT ----------------
    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [4:0]   key_code = 5'd0;
    logic         alu_ready = 1'b0;
    logic         res_valid = 1'b0;
    logic         res_error = 1'b0;
    logic [W-1:0] res_value = '0;
    logic         alu_valid;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_op;
    logic [W-1:0] disp_value;
    logic         disp_error;
    logic         busy;
    logic [2:0]   fsm_state;

    always #10 clock = ~clock;

    calc_key_sequencer #(.WIDTH(W), .DIGITS(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .key_code   (key_code),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .res_valid  (res_valid),
        .res_value  (res_value),
        .res_error  (res_error),
        .disp_value (disp_value),
        .disp_error (disp_error),
        .busy       (busy),
        .fsm_state  (fsm_state)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- reference model ----------------
    int m_mode, m_a, m_b, m_op, m_ca, m_cb, m_disp, m_err;
    logic [2+2*W-1:0] exp_q[$];   // expected requests {op, a, b}
    int noise_q[$];               // keys to press while the request is stalled
    int idx_val[16] = '{1, 4, 7, 0, 2, 5, 8, 15, 3, 6, 9, 14, 10, 11, 12, 13};

    task automatic m_clear();
        m_mode = M_A; m_a = 0; m_b = 0; m_op = 0; m_ca = 0; m_cb = 0;
        m_disp = 0; m_err = 0;
    endtask

    // kv: 0..9 digit, 10..13 op, 14 equals, 15 clear, negative = no key
    task automatic m_key(input int kv);
        if (kv < 0) return;
        case (m_mode)
            M_A: begin
                if (kv <= 9) begin
                    if (m_ca < 4) begin m_a = (m_a * 10 + kv) % 65536; m_ca++; end
                    m_disp = m_a;
                end else if (kv <= 13) begin
                    m_op = kv - 10; m_b = 0; m_cb = 0; m_mode = M_B;
                end else if (kv == 15) m_clear();
            end
            M_B: begin
                if (kv <= 9) begin
                    if (m_cb < 4) begin m_b = (m_b * 10 + kv) % 65536; m_cb++; end
                    m_disp = m_b;
                end else if (kv <= 13) begin
                    if (m_cb == 0) m_op = kv - 10;
                end else if (kv == 14) begin
                    if (m_cb > 0) begin
                        exp_q.push_back({m_op[1:0], m_a[W-1:0], m_b[W-1:0]});
                        m_mode = M_BUSY;
                    end
                end else m_clear();
            end
            M_SHOW: begin
                if (kv <= 9) begin
                    m_a = kv; m_ca = 1; m_disp = kv; m_mode = M_A;
                end else if (kv <= 13) begin
                    m_op = kv - 10; m_b = 0; m_cb = 0; m_mode = M_B;
                end else if (kv == 15) m_clear();
            end
            M_ERR: if (kv == 15) m_clear();
            default: ;
        endcase
    endtask

    task automatic m_result(input int v, input bit e);
        if (m_mode != M_BUSY) return;
        if (e) begin m_mode = M_ERR; m_disp = 0; m_err = 1; end
        else begin m_a = v; m_disp = v; m_mode = M_SHOW; end
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [4:0] code_of(input int kv);
        if (kv < 0) return 5'($urandom_range(1, 15));
        for (int i = 0; i < 16; i++)
            if (idx_val[i] == kv) return 5'(16 + i);
        return 5'd0;
    endfunction

    // All driver tasks start and end on a falling edge.
    task automatic do_reset();
        reset_n = 1'b0; key_code = 5'd0; alu_ready = 1'b0; res_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        m_clear();
        exp_q.delete();
    endtask

    task automatic press(input int kv);
        key_code = code_of(kv);
        @(negedge clock);
        key_code = 5'd0;
        m_key(kv);
    endtask

    task automatic press_seq(input int keys[$]);
        foreach (keys[i]) press(keys[i]);
    endtask

    // Waits (bounded) for a request, stalls alu_ready for 'delay' cycles
    // (optionally pressing keys meanwhile), then accepts it.
    task automatic alu_handshake(input int delay, input bit noisy, output bit seen,
                                 output bit held, output logic [2+2*W-1:0] got);
        int n = 0;
        seen = 1'b0; held = 1'b1; got = 'x;
        while (alu_valid !== 1'b1 && n < 16) begin @(negedge clock); n++; end
        if (alu_valid !== 1'b1) return;
        seen = 1'b1;
        got = {alu_op, alu_a, alu_b};
        for (int i = 0; i < delay; i++) begin
            if (noisy) begin
                int kv;
                kv = (noise_q.size() > 0) ? noise_q.pop_front() : int'($urandom_range(0, 15));
                key_code = code_of(kv);
                m_key(kv);
            end
            @(negedge clock);
            if (alu_valid !== 1'b1 || {alu_op, alu_a, alu_b} !== got) held = 1'b0;
        end
        key_code = 5'd0;
        alu_ready = 1'b1;
        @(negedge clock);
        alu_ready = 1'b0;
    endtask

    task automatic alu_result(input logic [W-1:0] v, input bit e);
        res_valid = 1'b1; res_value = v; res_error = e;
        @(negedge clock);
        res_valid = 1'b0; res_value = '0; res_error = 1'b0;
        m_result(int'(v), e);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        tests++;
        if ({alu_valid, alu_a, alu_b, alu_op, disp_value, disp_error, busy} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got valid=%0b a=%0d b=%0d op=%0d disp=%0d err=%0b busy=%0b want all 0",
                     alu_valid, alu_a, alu_b, alu_op, disp_value, disp_error, busy);
        end
        tests++;
        if (fsm_state !== 3'd0) begin
            fails++; $display("FAIL reset_state got %0d want 0", fsm_state);
        end
    endtask

    task automatic test_basic_add();
        bit seen, held; logic [2+2*W-1:0] got, exp;
        do_reset();
        press_seq('{1, 2, 10});
        tests++;
        if (disp_value !== 16'd12) begin fails++; $display("FAIL add_disp_a got %0d want 12", disp_value); end
        press(3);
        tests++;
        if (disp_value !== 16'd3) begin fails++; $display("FAIL add_disp_b got %0d want 3", disp_value); end
        press(14);
        tests++;
        if (alu_valid !== 1'b1 || busy !== 1'b1) begin
            fails++; $display("FAIL add_latency got valid=%0b busy=%0b want 1/1", alu_valid, busy);
        end
        alu_handshake(0, 1'b0, seen, held, got);
        exp = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        tests++;
        if (!seen || got !== exp || got !== {2'd0, 16'd12, 16'd3}) begin
            fails++; $display("FAIL add_request got %0h want %0h", got, exp);
        end
        tests++;
        if (alu_valid !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL add_single_cycle got valid=%0b busy=%0b want 0/1", alu_valid, busy);
        end
        alu_result(16'd15, 1'b0);
        tests++;
        if (disp_value !== 16'd15 || disp_error !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL add_result got disp=%0d err=%0b busy=%0b want 15/0/0", disp_value, disp_error, busy);
        end
    endtask

    task automatic test_digit_limit();
        do_reset();
        press_seq('{1, 2, 3, 4, 5});
        tests++;
        if (disp_value !== 16'd1234) begin fails++; $display("FAIL digit_limit got %0d want 1234", disp_value); end
        press(15);
        tests++;
        if (disp_value !== 16'd0 || fsm_state !== 3'd0) begin
            fails++; $display("FAIL digit_clear got disp=%0d state=%0d want 0/0", disp_value, fsm_state);
        end
        press_seq('{0, 0, 1, 2, 7});
        tests++;
        if (disp_value !== 16'd12) begin fails++; $display("FAIL leading_zeros got %0d want 12", disp_value); end
    endtask

    task automatic test_ready_stall();
        bit seen, held; logic [2+2*W-1:0] got, exp;
        do_reset();
        press_seq('{4, 12, 6, 14});
        noise_q = '{7, 15, 15};
        alu_handshake(3, 1'b1, seen, held, got);
        exp = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        tests++;
        if (!seen || !held || got !== exp || got !== {2'd2, 16'd4, 16'd6}) begin
            fails++; $display("FAIL stall_request seen=%0b held=%0b got %0h want %0h", seen, held, got, exp);
        end
        tests++;
        if (alu_valid !== 1'b0 || busy !== 1'b1 || disp_value !== 16'd6) begin
            fails++; $display("FAIL stall_accept got valid=%0b busy=%0b disp=%0d want 0/1/6", alu_valid, busy, disp_value);
        end
        alu_result(16'd24, 1'b0);
        tests++;
        if (disp_value !== 16'd24 || fsm_state !== 3'd4) begin
            fails++; $display("FAIL stall_result got disp=%0d state=%0d want 24/4", disp_value, fsm_state);
        end
    endtask

    task automatic test_error();
        bit seen, held; logic [2+2*W-1:0] got, exp;
        do_reset();
        press_seq('{8, 13, 0, 14});
        alu_handshake(1, 1'b0, seen, held, got);
        exp = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        tests++;
        if (!seen || got !== exp || got !== {2'd3, 16'd8, 16'd0}) begin
            fails++; $display("FAIL err_request got %0h want %0h", got, exp);
        end
        alu_result(16'd1234, 1'b1);
        tests++;
        if (disp_error !== 1'b1 || disp_value !== 16'd0) begin
            fails++; $display("FAIL err_flag got err=%0b disp=%0d want 1/0", disp_error, disp_value);
        end
        press(5);
        tests++;
        if (disp_error !== 1'b1 || disp_value !== 16'd0) begin
            fails++; $display("FAIL err_ignore got err=%0b disp=%0d want 1/0", disp_error, disp_value);
        end
        press(15);
        tests++;
        if (disp_error !== 1'b0 || disp_value !== 16'd0 || fsm_state !== 3'd0) begin
            fails++; $display("FAIL err_clear got err=%0b disp=%0d state=%0d want 0/0/0", disp_error, disp_value, fsm_state);
        end
    endtask

    task automatic test_chain();
        bit seen, held; logic [2+2*W-1:0] got, exp;
        do_reset();
        press_seq('{9, 10, 6, 14});
        alu_handshake(0, 1'b0, seen, held, got);
        void'(exp_q.pop_front());
        alu_result(16'd15, 1'b0);
        press_seq('{11, 5, 14});
        alu_handshake(0, 1'b0, seen, held, got);
        exp = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        tests++;
        if (!seen || got !== exp || got !== {2'd1, 16'd15, 16'd5}) begin
            fails++; $display("FAIL chain_request got %0h want %0h", got, exp);
        end
        alu_result(16'd10, 1'b0);
        tests++;
        if (disp_value !== 16'd10) begin fails++; $display("FAIL chain_result got %0d want 10", disp_value); end
        press(4);
        tests++;
        if (disp_value !== 16'd4 || fsm_state !== 3'd0) begin
            fails++; $display("FAIL chain_new_digit got disp=%0d state=%0d want 4/0", disp_value, fsm_state);
        end
    endtask

    task automatic test_op_replace();
        bit seen, held; logic [2+2*W-1:0] got, exp;
        do_reset();
        press_seq('{5, 10, 14});
        tests++;
        if (alu_valid !== 1'b0 || busy !== 1'b0 || disp_value !== 16'd5) begin
            fails++; $display("FAIL equals_no_b got valid=%0b busy=%0b disp=%0d want 0/0/5", alu_valid, busy, disp_value);
        end
        press_seq('{12, 2, 11, 14});
        alu_handshake(0, 1'b0, seen, held, got);
        exp = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        tests++;
        if (!seen || got !== exp || got !== {2'd2, 16'd5, 16'd2}) begin
            fails++; $display("FAIL op_replace got %0h want %0h", got, exp);
        end
        alu_result(16'd10, 1'b0);
    endtask

    task automatic test_reset_wait();
        bit seen, held; logic [2+2*W-1:0] got;
        do_reset();
        press_seq('{3, 10, 4, 14});
        alu_handshake(0, 1'b0, seen, held, got);
        do_reset();
        tests++;
        if ({alu_valid, alu_a, alu_b, alu_op, disp_value, disp_error, busy} !== '0 || fsm_state !== 3'd0) begin
            fails++; $display("FAIL reset_in_wait got valid=%0b disp=%0d busy=%0b state=%0d want all 0",
                              alu_valid, disp_value, busy, fsm_state);
        end
        alu_result(16'd7, 1'b0);
        tests++;
        if (disp_value !== 16'd0 || fsm_state !== 3'd0) begin
            fails++; $display("FAIL late_result got disp=%0d state=%0d want 0/0", disp_value, fsm_state);
        end
        press(9);
        tests++;
        if (disp_value !== 16'd9) begin fails++; $display("FAIL after_reset_digit got %0d want 9", disp_value); end
    endtask

    task automatic test_random();
        bit seen, held; logic [2+2*W-1:0] got, exp;
        do_reset();
        for (int it = 0; it < 400; it++) begin
            int r, kv;
            r = $urandom_range(0, 99);
            if (r < 55)      kv = $urandom_range(0, 9);
            else if (r < 75) kv = $urandom_range(10, 13);
            else if (r < 86) kv = 14;
            else if (r < 92) kv = 15;
            else             kv = -1;
            press(kv);
            tests++;
            if (disp_value !== m_disp[W-1:0] || disp_error !== m_err[0]) begin
                fails++; $display("FAIL rand_disp it=%0d key=%0d got %0d/%0b want %0d/%0d",
                                  it, kv, disp_value, disp_error, m_disp, m_err);
            end
            if (m_mode == M_BUSY) begin
                tests++;
                if (alu_valid !== 1'b1 || busy !== 1'b1) begin
                    fails++; $display("FAIL rand_issue it=%0d got valid=%0b busy=%0b want 1/1", it, alu_valid, busy);
                end
                alu_handshake($urandom_range(0, 3), 1'b1, seen, held, got);
                exp = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
                tests++;
                if (!seen || !held || got !== exp || alu_valid !== 1'b0) begin
                    fails++; $display("FAIL rand_request it=%0d seen=%0b held=%0b got %0h want %0h",
                                      it, seen, held, got, exp);
                end
                if (!seen) begin
                    do_reset();
                    continue;
                end
                repeat ($urandom_range(0, 2)) @(negedge clock);
                alu_result(16'($urandom_range(0, 65535)), $urandom_range(0, 5) == 0);
                tests++;
                if (disp_value !== m_disp[W-1:0] || disp_error !== m_err[0] || busy !== 1'b0) begin
                    fails++; $display("FAIL rand_result it=%0d got %0d/%0b busy=%0b want %0d/%0d/0",
                                      it, disp_value, disp_error, busy, m_disp, m_err);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        m_clear();
        @(negedge clock);
        test_reset();
        test_basic_add();
        test_digit_limit();
        test_ready_stall();
        test_error();
        test_chain();
        test_op_replace();
        test_reset_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
